// File: rtl/uart_cmd_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_responder_pkg
// Purpose  : Shared frame constants, status codes and FSM encoding for the
//            UART command responder.
// Revision : 1.0
// ============================================================================
package uart_cmd_responder_pkg;

    localparam logic [7:0] SOF_REQ = 8'hA5;
    localparam logic [7:0] SOF_RSP = 8'h5A;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_PING  = 8'h03;

    localparam logic [7:0] STATUS_OK       = 8'h00;
    localparam logic [7:0] STATUS_BAD_CHK  = 8'h01;
    localparam logic [7:0] STATUS_BAD_CMD  = 8'h02;
    localparam logic [7:0] STATUS_BAD_ADDR = 8'h03;

    localparam int REG_DEPTH = 16;
    localparam int REG_AW    = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_CMD  = 3'd1,
        ST_GET_ADDR = 3'd2,
        ST_GET_DATA = 3'd3,
        ST_GET_CHK  = 3'd4,
        ST_EXEC     = 3'd5,
        ST_TX_START = 3'd6,
        ST_TX_WAIT  = 3'd7
    } state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [7:0] c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_resp_regfile.sv
`default_nettype none
// ============================================================================
// Module   : uart_resp_regfile
// Purpose  : 16x8 register file, synchronous write, asynchronous read, with a
//            live tap of register 0.
// Revision : 1.0
// ============================================================================
module uart_resp_regfile
    import uart_cmd_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [REG_AW-1:0] i_raddr,
    output logic [7:0]        o_rdata,
    output logic [7:0]        o_cfg
);

    logic [7:0] r_mem [REG_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
    assign o_cfg   = r_mem[0];

endmodule
`default_nettype wire

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_responder
// Purpose  : Parses 5-byte request frames from the UART receiver, executes
//            them on a 16x8 register file and sends a 5-byte reply frame.
// Revision : 1.0
// ============================================================================
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 500000,
    parameter logic [7:0] VERSION        = 8'h25
) (
    input  logic       MAX10_CLK1_50,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [7:0] cfg_out,
    output logic [7:0] err_cnt
);

    localparam int c_to_width = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_to_width-1:0] c_to_last = c_to_width'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] c_depth = 8'(REG_DEPTH);

    state_t                r_state;
    logic [7:0]            r_cmd;
    logic [7:0]            r_addr;
    logic [7:0]            r_data;
    logic [7:0]            r_chk;
    logic [c_to_width-1:0] r_to_cnt;
    logic [2:0]            r_idx;
    logic                  r_guard;
    logic [7:0]            r_buf [5];
    logic [7:0]            r_tx_data;
    logic                  r_tx_start;
    logic [7:0]            r_err_cnt;

    logic [7:0] w_status;
    logic [7:0] w_rdata;
    logic [7:0] w_rf_rdata;
    logic       w_we;

    uart_resp_regfile u_regfile (
        .clk     (MAX10_CLK1_50),
        .rst     (reset),
        .i_we    (w_we),
        .i_waddr (r_addr[REG_AW-1:0]),
        .i_wdata (r_data),
        .i_raddr (r_addr[REG_AW-1:0]),
        .o_rdata (w_rf_rdata),
        .o_cfg   (cfg_out)
    );

    // Error precedence: checksum, then command, then address (PING has no address).
    always_comb begin
        w_status = STATUS_OK;
        w_rdata  = 8'h00;
        if (frame_chk(r_cmd, r_addr, r_data) != r_chk) begin
            w_status = STATUS_BAD_CHK;
        end else if (r_cmd != CMD_WRITE && r_cmd != CMD_READ && r_cmd != CMD_PING) begin
            w_status = STATUS_BAD_CMD;
        end else if (r_cmd != CMD_PING && r_addr >= c_depth) begin
            w_status = STATUS_BAD_ADDR;
        end
        if (w_status == STATUS_OK) begin
            case (r_cmd)
                CMD_READ:  w_rdata = w_rf_rdata;
                CMD_WRITE: w_rdata = r_data;
                CMD_PING:  w_rdata = VERSION;
                default:   w_rdata = 8'h00;
            endcase
        end
    end

    assign w_we = (r_state == ST_EXEC) && (w_status == STATUS_OK) && (r_cmd == CMD_WRITE);

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cmd      <= 8'h00;
            r_addr     <= 8'h00;
            r_data     <= 8'h00;
            r_chk      <= 8'h00;
            r_to_cnt   <= '0;
            r_idx      <= 3'd0;
            r_guard    <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_err_cnt  <= 8'h00;
            for (int i = 0; i < 5; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_ready && rx_data == SOF_REQ) begin
                        r_state  <= ST_GET_CMD;
                        r_to_cnt <= '0;
                    end
                end

                ST_GET_CMD, ST_GET_ADDR, ST_GET_DATA, ST_GET_CHK: begin
                    if (rx_ready) begin
                        r_to_cnt <= '0;
                        case (r_state)
                            ST_GET_CMD:  begin r_cmd  <= rx_data; r_state <= ST_GET_ADDR; end
                            ST_GET_ADDR: begin r_addr <= rx_data; r_state <= ST_GET_DATA; end
                            ST_GET_DATA: begin r_data <= rx_data; r_state <= ST_GET_CHK;  end
                            default:     begin r_chk  <= rx_data; r_state <= ST_EXEC;     end
                        endcase
                    end else if (r_to_cnt == c_to_last) begin
                        r_state   <= ST_IDLE;
                        r_err_cnt <= sat_inc8(r_err_cnt);
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                // The first reply byte is launched here so tx_start lands one cycle after EXEC.
                ST_EXEC: begin
                    r_buf[0]   <= SOF_RSP;
                    r_buf[1]   <= r_cmd;
                    r_buf[2]   <= w_status;
                    r_buf[3]   <= w_rdata;
                    r_buf[4]   <= frame_chk(r_cmd, w_status, w_rdata);
                    r_idx      <= 3'd0;
                    r_tx_data  <= SOF_RSP;
                    r_tx_start <= 1'b1;
                    r_state    <= ST_TX_START;
                    if (w_status == STATUS_BAD_CHK) begin
                        r_err_cnt <= sat_inc8(r_err_cnt);
                    end
                end

                ST_TX_START: begin
                    r_tx_start <= 1'b0;
                    r_guard    <= 1'b1;
                    r_state    <= ST_TX_WAIT;
                end

                // tx_busy only rises the cycle after tx_start, so skip one cycle first.
                ST_TX_WAIT: begin
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (!tx_busy) begin
                        if (r_idx == 3'd4) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx      <= r_idx + 3'd1;
                            r_tx_data  <= r_buf[r_idx + 3'd1];
                            r_tx_start <= 1'b1;
                            r_state    <= ST_TX_START;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Byte-level command responder that sits on the far side of the UART link from the board controller. It consumes received bytes (rx_data/rx_ready from the UART receiver) and parses fixed 5-byte request frames. It executes each request against a 16×8 internal register file and returns a fixed 5-byte reply frame through the UART transmitter handshake (tx_data/tx_start/tx_busy).

## Interface
- TIMEOUT_CYCLES, 500000, inter-byte timeout in clock cycles (10 ms at 50 MHz)
- VERSION, 8'h25, data byte returned by PING
- MAX10_CLK1_50  in  1  single clock, 50 MHz
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte, valid only when rx_ready=1
- rx_ready  in  1  one-cycle pulse per received byte
- tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls; reset 8'h00
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data; reset 0
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start
- cfg_out  out  8  live copy of register 0; reset 8'h00
- err_cnt  out  8  saturating count of checksum errors plus timeouts; reset 8'h00

## Operation
- Request frame: 8'hA5, CMD, ADDR, DATA, CHK, with CHK = CMD^ADDR^DATA. DATA is present for every command.
- Commands:
  - 8'h01 WRITE: reg[ADDR] <= DATA.
  - 8'h02 READ: return reg[ADDR].
  - 8'h03 PING: return VERSION.
- Reply frame: 8'h5A, CMD echo, STATUS, RDATA, RCHK, with RCHK = CMD^STATUS^RDATA.
- STATUS values:
  - 8'h00 OK.
  - 8'h01 bad checksum.
  - 8'h02 unknown CMD.
  - 8'h03 ADDR ≥ 16 (not checked for PING).
- RDATA by case:
  - READ OK: reg value.
  - WRITE OK: echo of DATA.
  - PING: VERSION.
  - Any error: 8'h00.
- Error precedence: checksum, then CMD, then ADDR. A failed request never modifies the register file.
- FSM states:
  - IDLE: waits for rx_ready. A byte ≠ A5 is discarded silently. A5 → GET_CMD.
  - GET_CMD, GET_ADDR, GET_DATA, GET_CHK: each latches one byte on rx_ready and advances. GET_CHK → EXEC.
  - EXEC (1 cycle): computes STATUS and RDATA, performs the write, loads a 5-byte reply buffer, clears the byte index → TX_START.
  - TX_START: asserts tx_start for 1 cycle with tx_data = buf[idx] → TX_WAIT.
  - TX_WAIT: ignores tx_busy in its first cycle, then waits for tx_busy=0. Then idx==4 → IDLE, else idx+1 → TX_START.
- Timeout: in the GET_* states a counter increments each cycle without rx_ready and clears on rx_ready. When it reaches TIMEOUT_CYCLES-1, the FSM goes → IDLE with no reply and err_cnt increments.
- rx_ready during EXEC, TX_START or TX_WAIT: byte dropped, no state change. The responder is strictly half-duplex.
- An A5 received mid-frame is treated as ordinary data, with no resync. Resync happens via checksum error or timeout.
- err_cnt saturates at 8'hFF.
- reset in any state: immediate return to IDLE. Registers, counters and all outputs go to their reset values. A transmission in progress is abandoned.

## Timing
- The CHK byte's rx_ready in cycle N → EXEC in N+1.
- The register write is visible on cfg_out in N+2.
- tx_start is high in N+2 with tx_data=8'h5A.
- Consecutive tx_start pulses are separated by at least 3 cycles: start, guard cycle, busy-low check.
- tx_data changes only in the cycle of a new tx_start or on reset.
- Minimum frame acceptance: one byte per rx_ready; back-to-back rx_ready pulses on consecutive cycles are accepted.

## Structure
- Shared package holds:
  - SOF_REQ=8'hA5 and SOF_RSP=8'h5A.
  - CMD_WRITE/READ/PING codes.
  - STATUS codes.
  - FSM state encoding.
  - REG_DEPTH=16.
- One natural sub-module: uart_resp_regfile (16×8, sync write, async read, reset-to-zero, cfg_out tap).
- Checksum and FSM stay in the top.

## Test plan
- PING: send A5 03 00 00 03 → reply 5A 03 00 25 26; err_cnt=0.
- WRITE then READ: A5 01 00 3C 3D → reply 5A 01 00 3C 3D, cfg_out=3C in N+2. Then A5 02 00 00 02 → 5A 02 00 3C 3E.
- Bad checksum: A5 01 05 77 00 → reply 5A 01 01 00 00; reg[5] unchanged; err_cnt=1.
- Bad address and bad CMD:
  - A5 02 10 00 12 → 5A 02 03 00 01.
  - A5 07 00 00 07 → 5A 07 02 00 05.
- Timeout and junk: send 11 22, then A5 01, then idle TIMEOUT_CYCLES → no reply, err_cnt=1. A following valid PING is answered normally.
- Reset mid-reply: assert reset during the third reply byte's TX_WAIT → tx_start=0, tx_data=00, cfg_out=00, err_cnt=00. The next PING is answered in full.
